// File: rtl/fp_to_fixed.sv
// fp_to_fixed: packed float {sign, exp, mnt} -> signed fixed-point word.
// Three-stage pipeline: unpack/classify, align, sign/saturate.
// Zero-stall; a valid bit rides with each sample through vld_pipe.
// Latency is 3 register stages: a sample taken at edge t is on odata at t+2.
//
// Ports:
//   clk       clock, rising edge
//   reset     synchronous, active-high; clears valids and output registers
//   enable    input valid; idata sampled when high
//   idata     {sign, exp[I_EXP-1:0], mnt[I_MNT-1:0]}
//   odata     signed fixed-point result, O_FRAC fractional bits
//   out_valid one-cycle strobe per accepted sample
//   ovf       saturated or NaN/Inf input; qualified by out_valid
//
// Build option FP_TO_FIXED_RNE_EN: right-shift path rounds to nearest,
// ties to even, using guard/sticky bits. Undefined: truncate toward zero.
module fp_to_fixed #(
  parameter int I_EXP   = 8,
  parameter int I_MNT   = 23,
  parameter int I_DATA  = I_EXP + I_MNT + 1,
  parameter int O_WIDTH = 16,
  parameter int O_FRAC  = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [I_DATA-1:0]  idata,
  output logic [O_WIDTH-1:0] odata,
  output logic               out_valid,
  output logic               ovf
);

  localparam int STAGES = 3;
  localparam int FW     = I_MNT + 1;           // mantissa with hidden bit
  localparam int WW     = FW + O_WIDTH;        // alignment workspace
  localparam int BIAS   = 2 ** (I_EXP - 1) - 1;
  localparam int SH_OFF = BIAS + I_MNT - O_FRAC;
  // Shift spans roughly +/-(2^I_EXP + I_MNT + O_FRAC); add headroom + sign.
  localparam int SH_W   = I_EXP + $clog2(I_MNT + O_FRAC + 1) + 2;

  localparam logic [O_WIDTH-1:0] MAX_P = {1'b0, {(O_WIDTH-1){1'b1}}};
  localparam logic [O_WIDTH-1:0] MIN_N = {1'b1, {(O_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {CL_NUM, CL_ZERO, CL_NAN, CL_INF} cls_e;

  typedef struct packed {
    logic                   sign;
    cls_e                   cls;
    logic [FW-1:0]          mag;
    logic signed [SH_W-1:0] sh;
  } s1_t;

  typedef struct packed {
    logic                   sign;
    cls_e                   cls;
    logic [O_WIDTH-1:0]     mag;
    logic                   big;     // magnitude needs more than O_WIDTH bits
`ifdef FP_TO_FIXED_RNE_EN
    logic                   guard;
    logic                   sticky;
`endif
  } s2_t;

  logic [STAGES-1:0] vld_pipe;
  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  logic [O_WIDTH-1:0] res_d;
  logic               ovf_d;

  // ---------------- stage 1: unpack / classify ----------------
  logic [I_EXP-1:0] exp_f;
  logic [I_MNT-1:0] mnt_f;
  assign exp_f = idata[I_DATA-2 -: I_EXP];
  assign mnt_f = idata[I_MNT-1:0];

  always_comb begin
    s1_d      = '0;
    s1_d.sign = idata[I_DATA-1];
    s1_d.mag  = {1'b1, mnt_f};
    s1_d.sh   = $signed({{(SH_W-I_EXP){1'b0}}, exp_f}) - $signed(SH_W'(SH_OFF));
    if (exp_f == '0)       s1_d.cls = CL_ZERO;   // denormals flush to zero
    else if (&exp_f)       s1_d.cls = (mnt_f != '0) ? CL_NAN : CL_INF;
    else                   s1_d.cls = CL_NUM;
  end

  // ---------------- stage 2: align ----------------
  logic [WW-1:0]   lsh_w, rsh_w;
  logic [SH_W-1:0] rsh;
  logic [FW-1:0]   int_part;
`ifdef FP_TO_FIXED_RNE_EN
  logic [2*FW-1:0] ext;
`endif

  always_comb begin
    s2_d      = '0;
    s2_d.sign = s1_q.sign;
    s2_d.cls  = s1_q.cls;
    rsh       = -s1_q.sh;
    lsh_w     = {{O_WIDTH{1'b0}}, s1_q.mag} << s1_q.sh;
`ifdef FP_TO_FIXED_RNE_EN
    // Integer part in the top half, discarded fraction in the bottom half.
    // Shifts past FW leave the fraction's MSB clear, so no round-up.
    ext      = {s1_q.mag, {FW{1'b0}}} >> rsh;
    int_part = ext[2*FW-1:FW];
`else
    int_part = s1_q.mag >> rsh;
`endif
    rsh_w = {{O_WIDTH{1'b0}}, int_part};
    if (!s1_q.sh[SH_W-1]) begin
      if ($unsigned(s1_q.sh) >= SH_W'(O_WIDTH)) begin
        s2_d.big = 1'b1;
      end else begin
        s2_d.big = |lsh_w[WW-1:O_WIDTH];
        s2_d.mag = lsh_w[O_WIDTH-1:0];
      end
    end else begin
      s2_d.big = |rsh_w[WW-1:O_WIDTH];
      s2_d.mag = rsh_w[O_WIDTH-1:0];
`ifdef FP_TO_FIXED_RNE_EN
      s2_d.guard  = ext[FW-1];
      s2_d.sticky = |ext[FW-2:0];
`endif
    end
  end

  // ---------------- stage 3: round / sign / saturate ----------------
  logic [O_WIDTH:0]   rnd;
  logic [O_WIDTH-1:0] m3;
  logic               big3;

  always_comb begin
    rnd = {1'b0, s2_q.mag};
`ifdef FP_TO_FIXED_RNE_EN
    if (s2_q.guard && (s2_q.sticky || s2_q.mag[0])) rnd = rnd + 1'b1;
`endif
    big3  = s2_q.big | rnd[O_WIDTH];
    m3    = rnd[O_WIDTH-1:0];
    res_d = '0;
    ovf_d = 1'b0;
    unique case (s2_q.cls)
      CL_ZERO: ;
      CL_NAN:  ovf_d = 1'b1;
      CL_INF: begin
        res_d = s2_q.sign ? MIN_N : MAX_P;
        ovf_d = 1'b1;
      end
      default: begin
        if (!s2_q.sign) begin
          if (big3 || m3[O_WIDTH-1]) begin
            res_d = MAX_P;
            ovf_d = 1'b1;
          end else begin
            res_d = m3;
          end
        end else begin
          // -2^(O_WIDTH-1) is representable exactly; only beyond it saturates.
          if (big3 || (m3 > MIN_N)) begin
            res_d = MIN_N;
            ovf_d = 1'b1;
          end else begin
            res_d = '0 - m3;
          end
        end
      end
    endcase
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      odata    <= '0;
      ovf      <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-2:0], enable};
      if (enable)      s1_q <= s1_d;
      if (vld_pipe[0]) s2_q <= s2_d;
      if (vld_pipe[1]) begin
        odata <= res_d;
        ovf   <= ovf_d;
      end
    end
  end

  assign out_valid = vld_pipe[STAGES-1];

endmodule

// File: tb/tb_fp_to_fixed.sv
module tb_fp_to_fixed;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [31:0] idata;
  logic [15:0] odata;
  logic        out_valid, ovf;

  fp_to_fixed dut (
    .clk(clk), .reset(reset), .enable(enable), .idata(idata),
    .odata(odata), .out_valid(out_valid), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] din;
    logic [15:0] d;
    logic        o;
    int          c;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic        rst_q = 1'b0;
  logic        armed = 1'b0;
  logic [15:0] hold_d = '0;
  logic        hold_o = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  // Reference: decode the float as a real number, scale by 2^12,
  // truncate (or round half-even), then clamp to the Q3.12 range.
  function automatic real pow2(input int n);
    real r = 1.0;
    if (n >= 0) repeat (n) r = r * 2.0;
    else        repeat (-n) r = r / 2.0;
    return r;
  endfunction

  function automatic void ref_conv(input logic [31:0] x,
                                   output logic [15:0] d, output logic o);
    int  e  = int'(x[30:23]);
    real mr = real'(x[22:0]);
    real v, q, fr;
    int  qi;
    d = 16'h0000; o = 1'b0;
    if (e == 0) return;
    if (e == 255) begin
      o = 1'b1;
      if (x[22:0] == 0) d = x[31] ? 16'h8000 : 16'h7FFF;
      return;
    end
    v  = (1.0 + mr / 8388608.0) * pow2(e - 127 + 12);
    q  = $floor(v);
    fr = v - q;
`ifdef FP_TO_FIXED_RNE_EN
    if (q < 65536.0) begin
      qi = $rtoi(q);
      if (fr > 0.5 || (fr == 0.5 && (qi % 2 == 1))) q = q + 1.0;
    end
`endif
    if (!x[31]) begin
      if (q >= 32768.0) begin d = 16'h7FFF; o = 1'b1; end
      else begin qi = $rtoi(q); d = 16'(qi); end
    end else begin
      if (q > 32768.0) begin d = 16'h8000; o = 1'b1; end
      else begin qi = $rtoi(q); d = 16'(-qi); end
    end
  endfunction

  // One cycle of stimulus; called #1 after a rising edge.
  task automatic step(input logic en, input logic [31:0] din, input logic rst,
                      input logic use_c, input logic [15:0] cd, input logic co);
    exp_t e;
    reset  = rst;
    enable = en;
    idata  = din;
    if (en && !rst) begin
      e.din = din;
      e.c   = cyc;
      if (use_c) begin e.d = cd; e.o = co; end
      else ref_conv(din, e.d, e.o);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (rst) sb.delete();   // anything in flight is dropped by this edge
  endtask

  task automatic chk(input logic [31:0] din, input logic [15:0] cd, input logic co);
    step(1'b1, din, 1'b0, 1'b1, cd, co);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 32'h0, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  // Monitor: pops the scoreboard on out_valid, checks hold otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (rst_q) begin
      armed = 1'b1;
      total++;
      if (out_valid !== 1'b0 || odata !== 16'h0 || ovf !== 1'b0) begin
        bad++;
        $display("FAIL reset_state out_valid=%b odata=%h ovf=%b want 0/0000/0",
                 out_valid, odata, ovf);
      end
      hold_d = 16'h0;
      hold_o = 1'b0;
    end else if (armed) begin
      if (out_valid === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL spurious_valid odata=%h ovf=%b want no output", odata, ovf);
        end else begin
          e = sb.pop_front();
          if (odata !== e.d || ovf !== e.o || cyc != e.c + 3) begin
            bad++;
            $display("FAIL sample in=%h got odata=%h ovf=%b cyc=%0d want odata=%h ovf=%b cyc=%0d",
                     e.din, odata, ovf, cyc, e.d, e.o, e.c + 3);
          end
          hold_d = e.d;
          hold_o = e.o;
        end
      end else begin
        total++;
        if (out_valid !== 1'b0 || odata !== hold_d || ovf !== hold_o) begin
          bad++;
          $display("FAIL hold out_valid=%b odata=%h ovf=%b want 0/%h/%b",
                   out_valid, odata, ovf, hold_d, hold_o);
        end
      end
    end
  end

  logic [31:0] rd;
  logic        ren;

  initial begin
    reset = 1'b1; enable = 1'b0; idata = '0;
    // 1: reset for two cycles, then 1.0
    step(1'b0, 32'h0, 1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 16'h0, 1'b0);
    chk(32'h3F800000, 16'h1000, 1'b0);
    idle(4);
    // 2: back-to-back stream
    chk(32'hC0200000, 16'hD800, 1'b0);
    chk(32'h39800000, 16'h0001, 1'b0);
`ifdef FP_TO_FIXED_RNE_EN
    chk(32'h39C00000, 16'h0002, 1'b0);
`else
    chk(32'h39C00000, 16'h0001, 1'b0);
`endif
    chk(32'h00000001, 16'h0000, 1'b0);
    // 3: saturation boundaries
    chk(32'h42C80000, 16'h7FFF, 1'b1);
    chk(32'hC1000000, 16'h8000, 1'b0);
    chk(32'hC1100000, 16'h8000, 1'b1);
`ifdef FP_TO_FIXED_RNE_EN
    chk(32'h40FFFFFF, 16'h7FFF, 1'b1);
`else
    chk(32'h40FFFFFF, 16'h7FFF, 1'b0);
`endif
    // 4: special values
    chk(32'h7FC00000, 16'h0000, 1'b1);
    chk(32'hFF800000, 16'h8000, 1'b1);
    chk(32'h80000000, 16'h0000, 1'b0);
    chk(32'h3FC00000, 16'h1800, 1'b0);
    idle(4);
    // 5: gapped enable 1,0,1,0,0,1
    chk(32'h40000000, 16'h2000, 1'b0);
    idle(1);
    chk(32'hBF000000, 16'hF800, 1'b0);
    idle(2);
    chk(32'h40400000, 16'h3000, 1'b0);
    idle(4);
    // 6: reset lands with three samples in flight, then one right after
    chk(32'h3F800000, 16'h1000, 1'b0);
    chk(32'h40000000, 16'h2000, 1'b0);
    step(1'b1, 32'h40400000, 1'b1, 1'b1, 16'h3000, 1'b0);
    chk(32'h3E800000, 16'h0400, 1'b0);
    idle(4);
    // random stream against the real-number model
    for (int i = 0; i < 400; i++) begin
      ren = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 7))
        0:       rd = $urandom;
        1:       rd = {1'($urandom), 8'd0, 23'($urandom)};
        2:       rd = {1'($urandom), 8'd255, ($urandom_range(0, 1) == 0) ? 23'd0 : 23'($urandom)};
        default: rd = {1'($urandom), 8'($urandom_range(108, 142)), 23'($urandom)};
      endcase
      step(ren, rd, 1'b0, 1'b0, 16'h0, 1'b0);
    end
    // drain with a bound
    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain outstanding=%0d want 0", sb.size());
    end
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_to_fixed.md
Name: fp_to_fixed

Overview:
Converts a packed floating-point sample (sign, I_EXP exponent, I_MNT mantissa, the same format as fp_add's odata) into a signed two's-complement fixed-point word for the fixed-point datapath. It sits at the boundary where fp_add results are handed back to fixed-point processing, and performs the reverse of the fixed-to-float conversion that feeds fp_add. It is a 3-stage pipeline with a valid shift register, saturation and an overflow flag.

Parameters:
I_EXP, 8, exponent width; bias = 2^(I_EXP-1)-1
I_MNT, 23, stored mantissa width; hidden bit is implicit
I_DATA, I_EXP+I_MNT+1, packed float width
O_WIDTH, 16, fixed-point output width, signed
O_FRAC, 12, fractional bits of output (default format is Q3.12)

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  per-cycle input-valid; idata is sampled when enable=1
idata  input  I_DATA  {sign, exp[I_EXP-1:0], mnt[I_MNT-1:0]}
odata  output  O_WIDTH  converted signed fixed-point value
out_valid  output  1  odata holds a new result this cycle
ovf  output  1  result was saturated, or input was NaN/Inf; qualified by out_valid

Behaviour:
- Reset (synchronous, active-high) sets odata=0, out_valid=0, ovf=0 and clears all internal valid bits. In-flight samples are dropped. Reset has priority over enable.
- The pipeline advances every cycle and never stalls. A valid bit travels with each sample. A stage's data registers load only when its incoming valid bit is 1; otherwise they hold.
- Latency: a sample accepted at rising edge t appears on odata/out_valid after rising edge t+2, i.e. 3 register stages. Back-to-back enable gives 1 result per cycle.
- out_valid is high for exactly one cycle per accepted sample. When out_valid=0, odata/ovf hold their last values.
- Stage 1 (unpack/classify):
  - exp==0: value is zero. Denormals flush to zero; result 0, ovf=0.
  - exp==all-ones with mnt!=0: NaN; result 0, ovf=1.
  - exp==all-ones with mnt==0: Inf; result saturates by sign, ovf=1.
  - Otherwise: mag = {1, mnt}, and sh = exp - bias - I_MNT + O_FRAC, computed as a signed value wide enough for every case.
- Stage 2 (align):
  - sh >= 0: mag << sh. Overflow if any set bit lands at or above bit O_WIDTH-1, or if sh >= O_WIDTH.
  - sh < 0: mag >> -sh, truncating the magnitude (round toward zero). If -sh > I_MNT+1, the result is 0.
  - Guard and sticky bits are kept for the optional rounding feature.
- Stage 3 (sign/saturate):
  - Apply the sign to the magnitude.
  - Positive magnitude >= 2^(O_WIDTH-1) -> 2^(O_WIDTH-1)-1, ovf=1.
  - Negative magnitude == 2^(O_WIDTH-1) -> -2^(O_WIDTH-1) exactly, ovf=0.
  - Negative magnitude > 2^(O_WIDTH-1) -> -2^(O_WIDTH-1), ovf=1.
- Negative zero (sign=1, exp=0) outputs 0.
- Default parameters: positive saturation value 0x7FFF, negative saturation value 0x8000.

Optional Feature:
FP_TO_FIXED_RNE_EN
- Defined: the right-shift path rounds to nearest, ties to even, using guard + sticky bits. Rounding applies to the magnitude before the sign is applied. A round-up that reaches 2^(O_WIDTH-1) on a positive value saturates with ovf=1. Latency is unchanged.
- Undefined: truncation toward zero as in Behaviour; guard/sticky logic is not built.

Test Plan (defaults, Q3.12):
1. Reset held for 2 cycles, then enable=1 with idata=0x3F800000 (1.0) -> odata=0x1000, ovf=0, out_valid high for exactly one cycle, after edge t+2. Verify out_valid=0 and odata=0 throughout reset.
2. Back-to-back stream 0xC0200000 (-2.5), 0x39800000 (2^-12), 0x39C00000 (3*2^-13), 0x00000001 (denormal) -> 0xD800, 0x0001, then 0x0001 (truncate) or 0x0002 (RNE), then 0x0000. All four valid in consecutive cycles.
3. Saturation inputs:
   - 0x42C80000 (100.0) -> 0x7FFF, ovf=1
   - 0xC1000000 (-8.0) -> 0x8000, ovf=0
   - 0xC1100000 (-9.0) -> 0x8000, ovf=1
   - 0x40FFFFFF (just below 8.0) -> 0x7FFF, ovf=0 without RNE; ovf=1 with RNE
4. Special values: 0x7FC00000 (NaN) -> 0x0000, ovf=1; 0xFF800000 (-Inf) -> 0x8000, ovf=1; 0x80000000 (-0) -> 0x0000, ovf=0.
5. Gapped enable pattern 1,0,1,0,0,1 with distinct values -> out_valid reproduces the same pattern delayed 2 edges, and odata holds during gaps.
6. Reset asserted for one cycle while 3 samples are in flight -> no out_valid for those samples. A sample accepted in the cycle after reset deasserts is output normally.
